// File: rtl/uart_rx_frame_ctrl.sv
// Frame checker behind the UART receiver: SYNC, LEN, payload, CSUM; releases payload after checksum.
// Optional inter-byte timeout enabled by defining UART_RX_FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl #(
    parameter int unsigned MAX_LEN      = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 4340
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_RX_DV,
    input  logic [7:0]  i_RX_Byte,
    output logic [7:0]  o_Frame_Data,
    output logic        o_Frame_Valid,
    output logic        o_Frame_Last,
    input  logic        i_Frame_Ready,
    output logic        o_Err_Csum,
    output logic        o_Err_Len,
    output logic        o_Err_Overrun,
    output logic        o_Err_Timeout,
    output logic [15:0] o_Frame_Count
);

    localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {StHunt, StLen, StPayload, StCsum, StDrain} state_e;

    state_e     state_q;
    logic [7:0] len_q;
    logic [7:0] sum_q;
    logic [7:0] wr_idx_q;
    logic [7:0] rd_idx_q;
    logic [7:0] mem_q [MAX_LEN];

    logic       timeout_hit;
    logic       len_bad;
    logic [7:0] rd_next;

    assign len_bad = (i_RX_Byte == 8'd0) || (32'(i_RX_Byte) > MAX_LEN);
    assign rd_next = rd_idx_q + 8'd1;

`ifdef UART_RX_FRAME_TIMEOUT_EN
    logic [15:0] idle_q;
    logic        frame_active;

    assign frame_active = (state_q == StLen) || (state_q == StPayload) || (state_q == StCsum);
    // A DV in the expiry cycle takes priority over the timeout.
    assign timeout_hit  = frame_active && !i_RX_DV && (idle_q == 16'(TIMEOUT_CLKS - 1));

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            idle_q        <= 16'd0;
            o_Err_Timeout <= 1'b0;
        end else begin
            o_Err_Timeout <= timeout_hit;
            if (frame_active && !i_RX_DV && !timeout_hit) begin
                idle_q <= idle_q + 16'd1;
            end else begin
                idle_q <= 16'd0;
            end
        end
    end
`else
    assign timeout_hit   = 1'b0;
    assign o_Err_Timeout = 1'b0;
`endif

    // Payload buffer has no reset; contents are only read after being written.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset && state_q == StPayload && i_RX_DV) begin
            mem_q[wr_idx_q[IdxW-1:0]] <= i_RX_Byte;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q       <= StHunt;
            len_q         <= 8'd0;
            sum_q         <= 8'd0;
            wr_idx_q      <= 8'd0;
            rd_idx_q      <= 8'd0;
            o_Frame_Data  <= 8'd0;
            o_Frame_Valid <= 1'b0;
            o_Frame_Last  <= 1'b0;
            o_Err_Csum    <= 1'b0;
            o_Err_Len     <= 1'b0;
            o_Err_Overrun <= 1'b0;
            o_Frame_Count <= 16'd0;
        end else begin
            o_Err_Csum    <= 1'b0;
            o_Err_Len     <= 1'b0;
            o_Err_Overrun <= 1'b0;
            unique case (state_q)
                StHunt: begin
                    if (i_RX_DV && i_RX_Byte == SYNC_BYTE) begin
                        state_q <= StLen;
                    end
                end
                StLen: begin
                    if (i_RX_DV) begin
                        if (len_bad) begin
                            o_Err_Len <= 1'b1;
                            state_q   <= StHunt;
                        end else begin
                            len_q    <= i_RX_Byte;
                            sum_q    <= i_RX_Byte;
                            wr_idx_q <= 8'd0;
                            state_q  <= StPayload;
                        end
                    end else if (timeout_hit) begin
                        state_q <= StHunt;
                    end
                end
                StPayload: begin
                    if (i_RX_DV) begin
                        sum_q <= sum_q + i_RX_Byte;
                        // Wrap the index on the final write so it stays below MAX_LEN.
                        if (wr_idx_q == len_q - 8'd1) begin
                            wr_idx_q <= 8'd0;
                            state_q  <= StCsum;
                        end else begin
                            wr_idx_q <= wr_idx_q + 8'd1;
                        end
                    end else if (timeout_hit) begin
                        state_q <= StHunt;
                    end
                end
                StCsum: begin
                    if (i_RX_DV) begin
                        if (i_RX_Byte == sum_q) begin
                            rd_idx_q      <= 8'd0;
                            o_Frame_Valid <= 1'b1;
                            o_Frame_Data  <= mem_q[0];
                            o_Frame_Last  <= (len_q == 8'd1);
                            state_q       <= StDrain;
                        end else begin
                            o_Err_Csum <= 1'b1;
                            state_q    <= StHunt;
                        end
                    end else if (timeout_hit) begin
                        state_q <= StHunt;
                    end
                end
                StDrain: begin
                    if (i_RX_DV) begin
                        o_Err_Overrun <= 1'b1;
                    end
                    if (o_Frame_Valid && i_Frame_Ready) begin
                        if (o_Frame_Last) begin
                            o_Frame_Valid <= 1'b0;
                            o_Frame_Last  <= 1'b0;
                            rd_idx_q      <= 8'd0;
                            o_Frame_Count <= o_Frame_Count + 16'd1;
                            state_q       <= StHunt;
                        end else begin
                            rd_idx_q     <= rd_next;
                            o_Frame_Data <= mem_q[rd_next[IdxW-1:0]];
                            o_Frame_Last <= (rd_next == len_q - 8'd1);
                        end
                    end
                end
                default: state_q <= StHunt;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed vector table, corner sequences and randomized frames
// checked against a stream-parsing reference model.
module tb_uart_rx_frame_ctrl;

    localparam int unsigned MaxLen      = 16;
    localparam logic [7:0]  Sync        = 8'hA5;
    localparam int unsigned TimeoutClks = 4340;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [23:0][7:0] stim;
        int               n;
        logic [23:0][7:0] dat;
        logic [23:0]      last;
        int               nd;
        int               csum;
        int               len;
        int               frames;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dv = 1'b0;
    logic [7:0]  rx = 8'h00;
    logic        rdy = 1'b0;
    logic [7:0]  frame_data;
    logic        frame_valid;
    logic        frame_last;
    logic        err_csum;
    logic        err_len;
    logic        err_ovr;
    logic        err_tmo;
    logic [15:0] frame_count;

    uart_rx_frame_ctrl #(
        .MAX_LEN     (MaxLen),
        .SYNC_BYTE   (Sync),
        .TIMEOUT_CLKS(TimeoutClks)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_RX_DV      (dv),
        .i_RX_Byte    (rx),
        .o_Frame_Data (frame_data),
        .o_Frame_Valid(frame_valid),
        .o_Frame_Last (frame_last),
        .i_Frame_Ready(rdy),
        .o_Err_Csum   (err_csum),
        .o_Err_Len    (err_len),
        .o_Err_Overrun(err_ovr),
        .o_Err_Timeout(err_tmo),
        .o_Frame_Count(frame_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned ecount = 0;
    logic        rand_ready = 1'b0;

    always @(posedge clk) ecount <= ecount + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: collects transfers, counts error pulses, checks output hold under backpressure.
    logic [7:0] got_data[$];
    logic       got_last[$];
    int         got_csum, got_len, got_ovr, got_tmo;
    logic       prev_hold = 1'b0;
    logic       prev_rst = 1'b1;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    always @(negedge clk) begin
        if (frame_valid && rdy && !rst) begin
            got_data.push_back(frame_data);
            got_last.push_back(frame_last);
        end
        if (err_csum) got_csum++;
        if (err_len)  got_len++;
        if (err_ovr)  got_ovr++;
        if (err_tmo)  got_tmo++;
        if (prev_hold && !prev_rst) begin
            check("hold_valid", 32'(frame_valid), 32'd1);
            check("hold_data", {23'd0, frame_data, frame_last}, {23'd0, prev_data, prev_last});
        end
        prev_hold = frame_valid && !rdy;
        prev_rst  = rst;
        prev_data = frame_data;
        prev_last = frame_last;
    end

    task automatic clear_mon();
        got_data.delete();
        got_last.delete();
        got_csum = 0;
        got_len  = 0;
        got_ovr  = 0;
        got_tmo  = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [7:0] b);
        dv = 1'b1;
        rx = b;
        step();
        dv = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (frame_valid && k < 2000) begin
            step();
            k++;
        end
        if (k >= 2000) check(name, 32'(frame_valid), 32'd0);
    endtask

    // Expected results, filled by the table, the model or by hand.
    logic [7:0] exp_data[$];
    logic       exp_last[$];
    int         exp_csum, exp_len, exp_frames;

    task automatic clear_exp();
        exp_data.delete();
        exp_last.delete();
        exp_csum   = 0;
        exp_len    = 0;
        exp_frames = 0;
    endtask

    task automatic compare(input string name, input int exp_ovr, input int exp_tmo,
                           input logic [15:0] cnt0);
        int n;
        check({name, "_nbytes"}, 32'(got_data.size()), 32'(exp_data.size()));
        n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data[%0d]", name, i), 32'(got_data[i]), 32'(exp_data[i]));
            check($sformatf("%s_last[%0d]", name, i), 32'(got_last[i]), 32'(exp_last[i]));
        end
        check({name, "_err_csum"}, 32'(got_csum), 32'(exp_csum));
        check({name, "_err_len"}, 32'(got_len), 32'(exp_len));
        check({name, "_err_ovr"}, 32'(got_ovr), 32'(exp_ovr));
        check({name, "_err_tmo"}, 32'(got_tmo), 32'(exp_tmo));
        check({name, "_count"}, 32'(16'(frame_count - cnt0)), 32'(exp_frames));
    endtask

    // Reference model: parses the whole byte stream frame by frame.
    bq_t stim;

    task automatic model();
        int         i = 0;
        int         l;
        logic [7:0] s;
        clear_exp();
        while (i < stim.size()) begin
            if (stim[i] != Sync) begin
                i++;
                continue;
            end
            if (i + 1 >= stim.size()) break;
            l = int'(stim[i+1]);
            if (l == 0 || l > int'(MaxLen)) begin
                exp_len++;
                i += 2;
                continue;
            end
            if (i + 2 + l >= stim.size()) break;
            s = 8'(l);
            for (int j = 0; j < l; j++) s = s + stim[i+2+j];
            if (stim[i+2+l] == s) begin
                for (int j = 0; j < l; j++) begin
                    exp_data.push_back(stim[i+2+j]);
                    exp_last.push_back(j == l - 1);
                end
                exp_frames++;
            end else begin
                exp_csum++;
            end
            i += 3 + l;
        end
    endtask

    function automatic vec_t mk(input bq_t s, input bq_t d, input logic [23:0] lastm,
                                input int c, input int l, input int f);
        vec_t v;
        v = '0;
        for (int i = 0; i < s.size(); i++) v.stim[i] = s[i];
        for (int i = 0; i < d.size(); i++) v.dat[i] = d[i];
        v.n      = s.size();
        v.nd     = d.size();
        v.last   = lastm;
        v.csum   = c;
        v.len    = l;
        v.frames = f;
        return v;
    endfunction

    task automatic nominal();
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    endtask

    task automatic exp_nominal();
        clear_exp();
        exp_data = '{8'h11, 8'h22, 8'h33};
        exp_last = '{1'b0, 1'b0, 1'b1};
        exp_frames = 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[5];
        bq_t         qs, qd;
        logic [15:0] cnt0;
        int unsigned e0;
        int          k;

        // Directed vector table.
        qs = '{8'h00, 8'hFF, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        qd = '{8'h11, 8'h22, 8'h33};
        vecs[0] = mk(qs, qd, 24'h000004, 0, 0, 1);
        qs = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68, 8'hA5, 8'h01, 8'h7E, 8'h7F};
        qd = '{8'h7E};
        vecs[1] = mk(qs, qd, 24'h000001, 1, 0, 1);
        qs = '{8'hA5, 8'h00};
        qd.delete();
        vecs[2] = mk(qs, qd, 24'h0, 0, 1, 0);
        qs = '{8'hA5, 8'h11};
        vecs[3] = mk(qs, qd, 24'h0, 0, 1, 0);
        qs = '{8'hA5, 8'h10};
        for (int i = 1; i <= 16; i++) begin
            qs.push_back(8'(i));
            qd.push_back(8'(i));
        end
        qs.push_back(8'h98);
        vecs[4] = mk(qs, qd, 24'h008000, 0, 0, 1);

        // Reset state.
        step(); step();
        rst = 1'b0;
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_data", 32'(frame_data), 32'd0);
        check("rst_last", 32'(frame_last), 32'd0);
        check("rst_errs", {28'd0, err_csum, err_len, err_ovr, err_tmo}, 32'd0);
        check("rst_count", 32'(frame_count), 32'd0);

        rdy = 1'b1;
        for (int v = 0; v < 5; v++) begin
            clear_mon();
            cnt0 = frame_count;
            for (int i = 0; i < vecs[v].n; i++) send(vecs[v].stim[i]);
            wait_idle($sformatf("vec%0d_drain", v));
            step(); step();
            clear_exp();
            for (int i = 0; i < vecs[v].nd; i++) begin
                exp_data.push_back(vecs[v].dat[i]);
                exp_last.push_back(vecs[v].last[i]);
            end
            exp_csum   = vecs[v].csum;
            exp_len    = vecs[v].len;
            exp_frames = vecs[v].frames;
            compare($sformatf("vec%0d", v), 0, 0, cnt0);
        end

        // Backpressure with an overrun byte inside the stall window.
        clear_mon();
        cnt0 = frame_count;
        rdy = 1'b0;
        nominal();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(frame_valid), 32'd1);
            check("bp_data", 32'(frame_data), 32'h11);
            if (i == 1) begin
                dv = 1'b1;
                rx = 8'h55;
            end
            step();
            dv = 1'b0;
        end
        rdy = 1'b1;
        wait_idle("bp_drain");
        step(); step();
        exp_nominal();
        compare("bp", 1, 0, cnt0);

        // Timeout on a stalled frame.
        clear_mon();
        cnt0 = frame_count;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22);
        e0 = ecount;
`ifdef UART_RX_FRAME_TIMEOUT_EN
        k = 0;
        while (!err_tmo && k < int'(TimeoutClks) + 100) begin
            step();
            k++;
        end
        check("tmo_delay", 32'(ecount - e0), 32'(TimeoutClks));
        step();
        nominal();
        wait_idle("tmo_drain");
        step(); step();
        exp_nominal();
        compare("tmo", 0, 1, cnt0);
`else
        k = 0;
        repeat (10000) step();
        check("no_tmo_cycles", 32'(ecount - e0), 32'd10000);
        check("no_tmo_valid", 32'(frame_valid), 32'd0);
        clear_exp();
        compare("no_tmo", 0, 0, cnt0);
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif

        // Reset while draining, then a clean frame.
        clear_mon();
        rdy = 1'b0;
        nominal();
        check("rd_first", {23'd0, frame_valid, frame_data}, {23'd0, 1'b1, 8'h11});
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        check("rd_second", {23'd0, frame_valid, frame_data}, {23'd0, 1'b1, 8'h22});
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rd_valid", 32'(frame_valid), 32'd0);
        check("rd_last", 32'(frame_last), 32'd0);
        check("rd_count", 32'(frame_count), 32'd0);
        clear_mon();
        rdy = 1'b1;
        nominal();
        wait_idle("rd_drain");
        step(); step();
        exp_nominal();
        compare("rd", 0, 0, 16'd0);

        // Randomized frame mix with random backpressure.
        stim.delete();
        for (int u = 0; u < 40; u++) begin
            int         kind;
            int         l;
            logic [7:0] s;
            logic [7:0] b;
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    b = 8'($urandom);
                    if (b == Sync) b = 8'h00;
                    stim.push_back(b);
                end
            end else if (kind == 3) begin
                stim.push_back(Sync);
                stim.push_back(($urandom_range(0, 1) == 0) ? 8'h00 :
                               8'($urandom_range(MaxLen + 1, 255)));
            end else begin
                l = int'($urandom_range(1, MaxLen));
                s = 8'(l);
                stim.push_back(Sync);
                stim.push_back(8'(l));
                for (int j = 0; j < l; j++) begin
                    b = 8'($urandom);
                    s = s + b;
                    stim.push_back(b);
                end
                if (kind == 2) s = s + 8'($urandom_range(1, 255));
                stim.push_back(s);
            end
        end
        model();
        clear_mon();
        cnt0 = frame_count;
        rand_ready = 1'b1;
        for (int i = 0; i < stim.size(); i++) begin
            send(stim[i]);
            wait_idle("rand_drain");
            repeat ($urandom_range(0, 2)) step();
        end
        rand_ready = 1'b0;
        rdy = 1'b1;
        wait_idle("rand_final");
        step(); step();
        compare("rand", 0, 0, cnt0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
